// File: rtl/imem_pkg.sv
// Shared constants, types and address-classification helper for the
// synchronous instruction memory.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        OK,
        MISALIGNED,
        OUT_OF_RANGE
    } fetch_status_t;

    // The PC is a signed byte address: bit 31 set means a negative PC.
    function automatic fetch_status_t classify_pc(input logic [31:0] pc,
                                                  input logic [31:0] depth_words);
        if (pc[1:0] != 2'b00) begin
            return MISALIGNED;
        end
        if (pc[31] || ({2'b00, pc[31:2]} >= depth_words)) begin
            return OUT_OF_RANGE;
        end
        return OK;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs LSB-first bytes into words and emits one
// write per completed word until the memory is full.
module imem_loader
    import imem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load_en,
    input  logic          i_load_valid,
    input  logic [7:0]    i_load_byte,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [31:0]   o_wr_data,
    output logic [AW-1:0] o_load_ptr,
    output logic          o_load_overflow
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    logic [1:0]    r_byte_cnt;
    logic [23:0]   r_word;
    logic [AW-1:0] r_ptr;
    logic          r_overflow;
    logic          w_byte_acc;

    assign w_byte_acc      = i_load_en && i_load_valid;
    assign o_wr_en         = w_byte_acc && (r_byte_cnt == 2'd3) && !r_overflow;
    assign o_wr_addr       = r_ptr;
    assign o_wr_data       = {i_load_byte, r_word};
    assign o_load_ptr      = r_ptr;
    assign o_load_overflow = r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 24'd0;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
        end else if (!i_load_en) begin
            // Leaving load mode discards any partially assembled word.
            r_byte_cnt <= 2'd0;
        end else if (i_load_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= {i_load_byte, r_word[23:8]};
            if (o_wr_en) begin
                if (r_ptr == LAST_IDX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_sync.sv
// Synchronously read instruction memory with 1-cycle fetch latency, stall
// hold, address fault detection and a run-time byte-stream loader.
module imem_sync
    import imem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_fetch_req,
    input  logic [31:0]   i_fetch_pc,
    input  logic          i_stall,
    output logic [31:0]   o_instr,
    output logic          o_instr_valid,
    output logic          o_fetch_fault,
    input  logic          i_load_en,
    input  logic          i_load_valid,
    input  logic [7:0]    i_load_byte,
    output logic [AW-1:0] o_load_ptr,
    output logic          o_load_overflow
);

    logic [31:0]   mem [0:DEPTH_WORDS-1];

    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [31:0]   w_wr_data;
    logic          w_accept;
    logic [AW-1:0] w_rd_addr;
    fetch_status_t w_status;

    logic [31:0]   r_rd_data;
    logic          r_valid;
    logic          r_fault;
    logic          r_sel_nop;

    imem_loader #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_loader (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_load_en      (i_load_en),
        .i_load_valid   (i_load_valid),
        .i_load_byte    (i_load_byte),
        .o_wr_en        (w_wr_en),
        .o_wr_addr      (w_wr_addr),
        .o_wr_data      (w_wr_data),
        .o_load_ptr     (o_load_ptr),
        .o_load_overflow(o_load_overflow)
    );

    assign w_accept  = i_fetch_req && !i_stall && !i_load_en;
    assign w_rd_addr = i_fetch_pc[AW+1:2];
    assign w_status  = classify_pc(i_fetch_pc, 32'(DEPTH_WORDS));

    // Array port kept free of reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            mem[w_wr_addr] <= w_wr_data;
        end
        if (w_accept) begin
            r_rd_data <= mem[w_rd_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
            r_sel_nop <= 1'b1;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_fault   <= (w_status != OK);
            r_sel_nop <= (w_status != OK);
        end else if (!i_stall || i_load_en) begin
            r_valid   <= 1'b0;
        end
    end

    // NOP substitution happens after the RAM register, not in the array read.
    assign o_instr       = r_sel_nop ? NOP_INSTR : r_rd_data;
    assign o_instr_valid = r_valid;
    assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: directed scenarios plus randomized
// fetch/stall traffic against a word-array reference model.
module tb_imem_sync;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int D1 = 1024;
    localparam int D4 = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Large instance
    logic        rst, fetch_req, stall, load_en, load_valid;
    logic [31:0] fetch_pc;
    logic [7:0]  load_byte;
    logic [31:0] instr;
    logic        instr_valid, fetch_fault, load_overflow;
    logic [9:0]  load_ptr;

    // Small instance
    logic        b_rst, b_fetch_req, b_stall, b_load_en, b_load_valid;
    logic [31:0] b_fetch_pc;
    logic [7:0]  b_load_byte;
    logic [31:0] b_instr;
    logic        b_instr_valid, b_fetch_fault, b_load_overflow;
    logic [1:0]  b_load_ptr;

    imem_sync #(.DEPTH_WORDS(D1)) dut (
        .i_clk(clk), .i_rst(rst), .i_fetch_req(fetch_req), .i_fetch_pc(fetch_pc),
        .i_stall(stall), .o_instr(instr), .o_instr_valid(instr_valid),
        .o_fetch_fault(fetch_fault), .i_load_en(load_en), .i_load_valid(load_valid),
        .i_load_byte(load_byte), .o_load_ptr(load_ptr), .o_load_overflow(load_overflow)
    );

    imem_sync #(.DEPTH_WORDS(D4)) dut4 (
        .i_clk(clk), .i_rst(b_rst), .i_fetch_req(b_fetch_req), .i_fetch_pc(b_fetch_pc),
        .i_stall(b_stall), .o_instr(b_instr), .o_instr_valid(b_instr_valid),
        .o_fetch_fault(b_fetch_fault), .i_load_en(b_load_en), .i_load_valid(b_load_valid),
        .i_load_byte(b_load_byte), .o_load_ptr(b_load_ptr), .o_load_overflow(b_load_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the large instance
    logic [31:0] m_mem [D1];
    int          m_ptr    = 0;
    bit          m_full   = 0;
    int          m_loaded = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void expect_pc(input logic [31:0] pc, input int depth,
                                      output logic [31:0] ins, output bit flt);
        longint spc;
        spc = longint'($signed(pc));
        if ((spc % 4) != 0 || spc < 0 || (spc / 4) >= depth) begin
            ins = NOP;
            flt = 1'b1;
        end else begin
            ins = m_mem[int'(spc / 4)];
            flt = 1'b0;
        end
    endfunction

    task automatic load_word(input logic [31:0] w);
        load_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_byte  = w[8*i +: 8];
            tick();
        end
        load_valid = 1'b0;
        if (!m_full) begin
            m_mem[m_ptr] = w;
            if (m_ptr + 1 > m_loaded) m_loaded = m_ptr + 1;
            if (m_ptr == D1 - 1) m_full = 1'b1;
            else m_ptr++;
        end
    endtask

    task automatic fetch_one(input logic [31:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_rst = 1'b1;
        tick(); tick();
        rst = 1'b0; b_rst = 1'b0;
        n_tests++;
        if (instr !== NOP || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got instr=%h valid=%b fault=%b exp %h 0 0", instr, instr_valid, fetch_fault, NOP);
        end
        n_tests++;
        if (load_ptr !== 10'd0 || load_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_loader: got ptr=%0d ovf=%b exp 0 0", load_ptr, load_overflow);
        end
        n_tests++;
        if (b_instr !== NOP || b_load_ptr !== 2'd0 || b_load_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_small: got instr=%h ptr=%0d ovf=%b", b_instr, b_load_ptr, b_load_overflow);
        end
    endtask

    task automatic test_load_first();
        logic [31:0] ei;
        bit ef;
        load_word(32'h00a00513);
        n_tests++;
        if (load_ptr !== 10'd1) begin
            n_fail++;
            $display("FAIL load_ptr_first: got %0d exp 1", load_ptr);
        end
        load_en = 1'b0;
        tick();
        fetch_one(32'd0);
        expect_pc(32'd0, D1, ei, ef);
        n_tests++;
        if (instr !== 32'h00a00513 || instr !== ei || instr_valid !== 1'b1 || fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_first: got %h v=%b f=%b exp 00a00513 1 0", instr, instr_valid, fetch_fault);
        end
        load_en = 1'b1;
        tick();
        n_tests++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_en_clears_valid: got %b exp 0", instr_valid);
        end
    endtask

    task automatic test_load_random();
        for (int i = 0; i < 63; i++) load_word($urandom);
        load_en = 1'b0;
        tick();
        n_tests++;
        if (load_ptr !== 10'(m_ptr) || load_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ptr_bulk: got %0d ovf=%b exp %0d 0", load_ptr, load_overflow, m_ptr);
        end
    endtask

    task automatic test_faults();
        logic [31:0] pcs [7];
        pcs[0] = 32'd2;
        pcs[1] = 32'd4096;
        pcs[2] = -32'sd4;
        pcs[3] = 32'd4092 + 32'd1;
        pcs[4] = 32'h8000_0000;
        pcs[5] = 32'(($urandom_range(0, 63) * 4) + $urandom_range(1, 3));
        pcs[6] = 32'(($urandom_range(1025, 9999)) * 4);
        for (int i = 0; i < 7; i++) begin
            fetch_one(pcs[i]);
            n_tests++;
            if (instr !== NOP || fetch_fault !== 1'b1 || instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_pc_%h: got %h v=%b f=%b exp %h 1 1", pcs[i], instr, instr_valid, fetch_fault, NOP);
            end
        end
        fetch_one(32'd4);
        n_tests++;
        if (instr !== m_mem[1] || fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clears: got %h f=%b exp %h 0", instr, fetch_fault, m_mem[1]);
        end
    endtask

    task automatic test_back_to_back();
        fetch_req = 1'b1; fetch_pc = 32'd0; stall = 1'b0;
        tick();
        n_tests++;
        if (instr !== m_mem[0] || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pc0: got %h v=%b exp %h 1", instr, instr_valid, m_mem[0]);
        end
        fetch_pc = 32'd4;
        tick();
        n_tests++;
        if (instr !== m_mem[1] || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pc4: got %h v=%b exp %h 1", instr, instr_valid, m_mem[1]);
        end
        fetch_pc = 32'd8; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (instr !== m_mem[1] || instr_valid !== 1'b1 || fetch_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_stall_%0d: got %h v=%b exp %h 1", i, instr, instr_valid, m_mem[1]);
            end
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (instr !== m_mem[2] || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pc8: got %h v=%b exp %h 1", instr, instr_valid, m_mem[2]);
        end
        fetch_req = 1'b0;
        tick();
        n_tests++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got v=%b exp 0", instr_valid);
        end
    endtask

    task automatic test_random_fetch();
        logic [31:0] e_instr, ni, pc;
        bit e_valid, e_fault, nf;
        int errs;
        errs = 0;
        fetch_one(32'd0);
        e_instr = m_mem[0]; e_valid = 1'b1; e_fault = 1'b0;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 9))
                0: pc = 32'(($urandom_range(0, m_loaded - 1) * 4) + $urandom_range(1, 3));
                1: pc = -32'($urandom_range(1, 1000) * 4);
                2: pc = 32'($urandom_range(D1, 200000) * 4);
                default: pc = 32'($urandom_range(0, m_loaded - 1) * 4);
            endcase
            fetch_pc  = pc;
            fetch_req = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            tick();
            if (fetch_req && !stall) begin
                expect_pc(pc, D1, ni, nf);
                e_instr = ni; e_fault = nf; e_valid = 1'b1;
            end else if (!stall) begin
                e_valid = 1'b0;
            end
            n_tests++;
            if (instr !== e_instr || instr_valid !== e_valid || fetch_fault !== e_fault) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random_fetch_c%0d: got %h v=%b f=%b exp %h %b %b", c, instr, instr_valid, fetch_fault, e_instr, e_valid, e_fault);
                errs++;
            end
        end
        fetch_req = 1'b0; stall = 1'b0;
        tick();
    endtask

    task automatic test_partial_discard();
        int p;
        p = m_ptr;
        load_en = 1'b1;
        load_valid = 1'b1; load_byte = 8'h11; tick();
        load_byte = 8'h22; tick();
        load_valid = 1'b0; load_en = 1'b0;
        tick();
        load_word(32'hDDCCBBAA);
        load_en = 1'b0;
        tick();
        n_tests++;
        if (load_ptr !== 10'(p + 1)) begin
            n_fail++;
            $display("FAIL partial_ptr: got %0d exp %0d", load_ptr, p + 1);
        end
        fetch_one(32'(p * 4));
        n_tests++;
        if (instr !== 32'hDDCCBBAA || fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_word: got %h f=%b exp ddccbbaa 0", instr, fetch_fault);
        end
    endtask

    task automatic test_reset_midload();
        fetch_one(32'd4);
        load_en = 1'b1;
        load_valid = 1'b1; load_byte = 8'h5A; tick();
        load_byte = 8'hA5; tick();
        load_valid = 1'b0;
        rst = 1'b1; load_en = 1'b0;
        tick();
        rst = 1'b0;
        m_ptr = 0; m_full = 1'b0;
        n_tests++;
        if (load_ptr !== 10'd0 || instr_valid !== 1'b0 || load_overflow !== 1'b0 || instr !== NOP) begin
            n_fail++;
            $display("FAIL rst_midload: got ptr=%0d v=%b ovf=%b instr=%h exp 0 0 0 %h", load_ptr, instr_valid, load_overflow, instr, NOP);
        end
        fetch_one(32'd0);
        n_tests++;
        if (instr !== m_mem[0]) begin
            n_fail++;
            $display("FAIL rst_keeps_mem: got %h exp %h", instr, m_mem[0]);
        end
        // A fresh word after reset must land at index 0 again.
        load_word(32'hCAFE0001);
        load_en = 1'b0;
        tick();
        fetch_one(32'd0);
        n_tests++;
        if (instr !== 32'hCAFE0001 || load_ptr !== 10'd1) begin
            n_fail++;
            $display("FAIL rst_reload: got %h ptr=%0d exp cafe0001 1", instr, load_ptr);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w [5];
        for (int k = 0; k < 5; k++) w[k] = $urandom;
        b_load_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                b_load_valid = 1'b1;
                b_load_byte  = w[k][8*i +: 8];
                tick();
            end
            b_load_valid = 1'b0;
            if (k == 2) begin
                n_tests++;
                if (b_load_ptr !== 2'd3 || b_load_overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_three_words: got ptr=%0d ovf=%b exp 3 0", b_load_ptr, b_load_overflow);
                end
            end
        end
        n_tests++;
        if (b_load_ptr !== 2'd3 || b_load_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_five_words: got ptr=%0d ovf=%b exp 3 1", b_load_ptr, b_load_overflow);
        end
        b_load_en = 1'b0;
        tick();
        n_tests++;
        if (b_load_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b exp 1", b_load_overflow);
        end
        for (int k = 0; k < 5; k++) begin
            b_fetch_req = 1'b1;
            b_fetch_pc  = 32'(k * 4);
            tick();
            n_tests++;
            if (k < 4) begin
                if (b_instr !== w[k] || b_fetch_fault !== 1'b0 || b_instr_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_word_%0d: got %h f=%b exp %h 0", k, b_instr, b_fetch_fault, w[k]);
                end
            end else if (b_instr !== NOP || b_fetch_fault !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_range: got %h f=%b exp %h 1", b_instr, b_fetch_fault, NOP);
            end
        end
        b_fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; stall = 1'b0;
        load_en = 1'b0; load_valid = 1'b0; load_byte = '0;
        b_rst = 1'b1; b_fetch_req = 1'b0; b_fetch_pc = '0; b_stall = 1'b0;
        b_load_en = 1'b0; b_load_valid = 1'b0; b_load_byte = '0;
        test_reset();
        test_load_first();
        test_load_random();
        test_faults();
        test_back_to_back();
        test_random_fetch();
        test_partial_discard();
        test_reset_midload();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
